regbank_rr_arbiter: RTL and testbench
=====================================

Name: regbank_rr_arbiter

Overview:
- Arbitrated controller for a small flip-flop register bank that two requesters share.
- The bank is DEPTH words of WIDTH bits, built from edge-triggered D flip-flops.
- Two independent requesters issue read or write transactions. A round-robin arbiter grants one at a time, and a 3-state FSM sequences the access and returns a one-cycle acknowledge with read data.
- Sits between requester logic and the storage element library as the sole owner of the bank.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, number of bank entries; must be a power of 2, minimum 2.
- AW, 2, address width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 transaction request.
- we0  input  1  requester 0 write enable (1 = write, 0 = read).
- addr0  input  AW  requester 0 address.
- wdata0  input  WIDTH  requester 0 write data.
- req1  input  1  requester 1 transaction request.
- we1  input  1  requester 1 write enable.
- addr1  input  AW  requester 1 address.
- wdata1  input  WIDTH  requester 1 write data.
- gnt0  output  1  requester 0 granted; operands captured.
- gnt1  output  1  requester 1 granted; operands captured.
- ack0  output  1  requester 0 transaction complete; rdata valid.
- ack1  output  1  requester 1 transaction complete; rdata valid.
- rdata  output  WIDTH  read data, or written data for a write.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset, sampled on the rising clk edge, and has priority over all other activity.
- Reset values:
  - gnt0 = gnt1 = ack0 = ack1 = busy = 0; rdata = 0.
  - All bank entries = 0.
  - FSM = IDLE.
  - Round-robin pointer last = 1, so requester 0 wins the first contention.
- IDLE (busy = 0), on an edge with any reqN = 1:
  - Select the winner. If only one request is high, that requester wins. If both are high, the winner is the requester that is not last.
  - Set gntW = 1 and capture weW, addrW and wdataW into internal operand registers.
  - Set last = W and go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS (busy = 1, gntW = 1 for exactly this cycle), on the next edge:
  - For a write, bank[addr] <= wdata and rdata <= wdata (write-through).
  - For a read, rdata <= bank[addr].
  - gntW <= 0, ackW <= 1, go to RELEASE.
- RELEASE (busy = 1, ackW = 1 for exactly this cycle), on the next edge: ackW <= 0, go to IDLE. Requests are not sampled in RELEASE.
- Latency and throughput: request sampled at edge E0 → grant during (E0, E1) → ack and rdata during (E1, E2). Minimum spacing is 3 cycles per transaction.
- rdata holds its last value until the next ack; it is not cleared when ack falls.
- Handshake:
  - Requester holds req and its operands stable until it sees gnt. Operands are captured at grant, so changes after grant are ignored.
  - A req dropped after grant does not cancel the transaction; ack is still issued.
  - A req still high after ack is treated as a new request at the first IDLE edge.
- gnt0 and gnt1 are never high together; likewise ack0 and ack1. At most one of gnt*/ack* is high in any cycle.
- Address range: the address uses the full AW bits, so no out-of-range case exists.
- Reset mid-operation: reset asserted on the edge that would end ACCESS aborts the transaction. No bank write occurs, no ack is issued, and the bank is cleared.
- Starvation bound: a continuously asserted request is granted within 6 cycles.

Test Plan:
- Reset then idle: assert reset 2 cycles, release, hold reqs low 5 cycles → all outputs 0, busy 0. Read all 4 addresses via req0 → rdata = 0x00 each.
- Single write/read: req0 = 1, we0 = 1, addr0 = 2, wdata0 = 0xA5 → gnt0 1 cycle after the sampling edge, then ack0 with rdata = 0xA5. Then req0 read addr 2 → ack0 with rdata = 0xA5.
- Simultaneous contention: out of reset, req0 and req1 both high held continuously, both reads → grants alternate gnt0, gnt1, gnt0, gnt1, each 3 cycles apart, never both high.
- Cross-requester visibility: req1 writes 0x3C to addr 1; then req0 reads addr 1 → ack0 with rdata = 0x3C; rdata stays 0x3C after ack0 falls.
- Operand capture: req0 write addr 3 data 0x11; change wdata0 to 0xFF and drop req0 in the cycle after gnt0 → ack0 still issued, later read of addr 3 = 0x11.
- Reset mid-op: write 0x77 to addr 0, then start a write of 0x55 to addr 0 and assert reset during the ACCESS cycle → no ack, busy = 0 next cycle, read of addr 0 = 0x00.

Source files
------------

// File: rtl/regbank_rr_arbiter.sv
// Two-requester round-robin controller that owns a small flip-flop register bank.
// Each granted transaction runs IDLE -> ACCESS -> RELEASE: grant in ACCESS, ack with rdata in RELEASE.
module regbank_rr_arbiter #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             we0,
   input  logic [AW-1:0]    addr0,
   input  logic [WIDTH-1:0] wdata0,
   input  logic             req1,
   input  logic             we1,
   input  logic [AW-1:0]    addr1,
   input  logic [WIDTH-1:0] wdata1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             ack0,
   output logic             ack1,
   output logic [WIDTH-1:0] rdata,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RELEASE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             last_q, last_d;
   logic             owner_q, owner_d;
   logic             op_we_q, op_we_d;
   logic [AW-1:0]    op_addr_q, op_addr_d;
   logic [WIDTH-1:0] op_wdata_q, op_wdata_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [WIDTH-1:0] bank_q [DEPTH];
   logic             bank_we;
   logic             win;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d    = state_q;
      last_d     = last_q;
      owner_d    = owner_q;
      op_we_d    = op_we_q;
      op_addr_d  = op_addr_q;
      op_wdata_d = op_wdata_q;
      rdata_d    = rdata_q;
      bank_we    = 1'b0;
      win        = 1'b0;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               // On contention the requester that did not win last time goes first.
               win        = (req0 && req1) ? ~last_q : req1;
               owner_d    = win;
               last_d     = win;
               op_we_d    = win ? we1 : we0;
               op_addr_d  = win ? addr1 : addr0;
               op_wdata_d = win ? wdata1 : wdata0;
               state_d    = ACCESS;
            end
         end
         ACCESS: begin
            bank_we = op_we_q;
            rdata_d = op_we_q ? op_wdata_q : bank_q[op_addr_q];
            state_d = RELEASE;
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         owner_q    <= 1'b0;
         op_we_q    <= 1'b0;
         op_addr_q  <= '0;
         op_wdata_q <= '0;
         rdata_q    <= '0;
         // NOTE: the bank is plain flops with a defined cleared state, so it is reset like any register.
         for (int i = 0; i < DEPTH; i++) begin
            bank_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         op_we_q    <= op_we_d;
         op_addr_q  <= op_addr_d;
         op_wdata_q <= op_wdata_d;
         rdata_q    <= rdata_d;
         if (bank_we) begin
            bank_q[op_addr_q] <= op_wdata_q;
         end
      end
   end

   // Handshake outputs decode from state and owner, so they are mutually exclusive by construction.
   assign gnt0  = (state_q == ACCESS)  && !owner_q;
   assign gnt1  = (state_q == ACCESS)  &&  owner_q;
   assign ack0  = (state_q == RELEASE) && !owner_q;
   assign ack1  = (state_q == RELEASE) &&  owner_q;
   assign busy  = (state_q != IDLE);
   assign rdata = rdata_q;

endmodule

// File: tb/tb_regbank_rr_arbiter.sv
// Scoreboard bench: a transaction-level model predicts winner, grant cycle and data;
// a negedge monitor compares every cycle of gnt/ack/busy/rdata against the queued predictions.
module tb_regbank_rr_arbiter;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   typedef struct {
      bit             valid;
      bit             we;
      logic [AW-1:0]  addr;
      logic [WIDTH-1:0] wdata;
   } txn_t;

   typedef struct {
      bit               id;
      logic [WIDTH-1:0] data;
      int unsigned      cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             req0, we0, req1, we1;
   logic [AW-1:0]    addr0, addr1;
   logic [WIDTH-1:0] wdata0, wdata1;
   logic             gnt0, gnt1, ack0, ack1, busy;
   logic [WIDTH-1:0] rdata;

   int unsigned      cyc = 0;
   int               n_checks = 0;
   int               n_errors = 0;
   exp_t             exp_q[$];
   logic [WIDTH-1:0] rdata_exp = '0;

   // Reference model state
   logic [WIDTH-1:0] bank_m [DEPTH];
   bit               last_m;
   txn_t             pend0, pend1;

   regbank_rr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
      .rdata(rdata), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: every non-reset cycle, compare outputs with what the scoreboard front predicts.
   always @(negedge clk) begin
      logic [1:0] exp_gnt, exp_ack;
      bit         pop;
      if (reset) begin
         exp_q.delete();
         rdata_exp = '0;
      end else begin
         exp_gnt = '0;
         exp_ack = '0;
         pop     = 1'b0;
         if (exp_q.size() > 0) begin
            if (cyc == exp_q[0].cyc) begin
               exp_gnt[exp_q[0].id] = 1'b1;
            end else if (cyc == exp_q[0].cyc + 1) begin
               exp_ack[exp_q[0].id] = 1'b1;
               rdata_exp = exp_q[0].data;
               pop = 1'b1;
            end
         end
         check("gnt",   32'({gnt1, gnt0}), 32'(exp_gnt));
         check("ack",   32'({ack1, ack0}), 32'(exp_ack));
         check("busy",  32'(busy), 32'(|{exp_gnt, exp_ack}));
         check("rdata", 32'(rdata), 32'(rdata_exp));
         if (pop) void'(exp_q.pop_front());
      end
   end

   task automatic drive_lines();
      req0 = pend0.valid; we0 = pend0.we; addr0 = pend0.addr; wdata0 = pend0.wdata;
      req1 = pend1.valid; we1 = pend1.we; addr1 = pend1.addr; wdata1 = pend1.wdata;
   endtask

   // After a grant the winner's lines are garbage; captured operands must be used instead.
   task automatic scramble(input bit id);
      if (id == 1'b0) begin
         req0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
         addr0 = 2'($urandom_range(0, 3)); wdata0 = 8'($urandom);
      end else begin
         req1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
         addr1 = 2'($urandom_range(0, 3)); wdata1 = 8'($urandom);
      end
   endtask

   function automatic txn_t mk(input bit we, input int addr, input int data);
      txn_t t;
      t.valid = 1'b1;
      t.we    = we;
      t.addr  = 2'(addr);
      t.wdata = 8'(data);
      return t;
   endfunction

   function automatic txn_t rand_txn();
      return mk(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 255));
   endfunction

   // Called one time unit after an edge that leaves the DUT in IDLE.
   task automatic run_slot();
      bit   w;
      txn_t t;
      exp_t e;
      drive_lines();
      @(posedge clk); #1;
      if (!pend0.valid && !pend1.valid) return;
      if (pend0.valid && pend1.valid) w = (last_m == 1'b0);
      else                            w = pend1.valid;
      t = w ? pend1 : pend0;
      e.id   = w;
      e.cyc  = cyc;
      e.data = t.we ? t.wdata : bank_m[t.addr];
      if (t.we) bank_m[t.addr] = t.wdata;
      exp_q.push_back(e);
      last_m = w;
      if (w) pend1.valid = 1'b0;
      else   pend0.valid = 1'b0;
      scramble(w);
      @(posedge clk); #1;
      scramble(w);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      while (pend0.valid || pend1.valid) run_slot();
   endtask

   task automatic apply_reset(input int n);
      reset = 1'b1;
      pend0.valid = 1'b0;
      pend1.valid = 1'b0;
      drive_lines();
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) bank_m[i] = '0;
      last_m = 1'b1;
   endtask

   initial begin
      pend0 = mk(0, 0, 0); pend0.valid = 1'b0;
      pend1 = mk(0, 0, 0); pend1.valid = 1'b0;
      reset = 1'b1;
      drive_lines();
      apply_reset(2);

      // Idle after reset, then every address reads back zero
      repeat (5) run_slot();
      for (int a = 0; a < DEPTH; a++) begin
         pend0 = mk(0, a, 0);
         run_slot();
      end

      // Single write then read-back
      pend0 = mk(1, 2, 8'hA5); run_slot();
      pend0 = mk(0, 2, 0);     run_slot();

      // Sustained contention from reset: grants alternate starting with requester 0
      apply_reset(1);
      for (int i = 0; i < 6; i++) begin
         if (!pend0.valid) pend0 = mk(0, $urandom_range(0, 3), 0);
         if (!pend1.valid) pend1 = mk(0, $urandom_range(0, 3), 0);
         run_slot();
      end
      drain();

      // Cross-requester visibility and rdata hold after ack
      pend1 = mk(1, 1, 8'h3C); run_slot();
      pend0 = mk(0, 1, 0);     run_slot();
      repeat (3) run_slot();

      // Operands captured at grant despite later line changes
      pend0 = mk(1, 3, 8'h11); run_slot();
      pend0 = mk(0, 3, 0);     run_slot();

      // Reset during ACCESS aborts the write and clears the bank
      pend0 = mk(1, 0, 8'h77); run_slot();
      pend0 = mk(1, 0, 8'h55);
      drive_lines();
      @(posedge clk); #1;
      apply_reset(1);
      pend0 = mk(0, 0, 0); run_slot();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         if (!pend0.valid && $urandom_range(0, 9) < 6) pend0 = rand_txn();
         if (!pend1.valid && $urandom_range(0, 9) < 6) pend1 = rand_txn();
         run_slot();
      end
      drain();
      repeat (3) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
